// File: rtl/muldiv_unit_if.sv
// Handshake and data bundle for muldiv_unit.
//   start/op/a/b : operation request, sampled only while the unit is idle
//   hi_wr/lo_wr  : direct HI/LO loads (MTHI/MTLO) from wr_data, honoured only while idle
//   busy/done    : operation in progress / one-cycle completion pulse
//   div_zero     : one-cycle pulse alongside done for a divide by zero
//   hi/lo        : architectural HI and LO registers
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_wr;
  logic             lo_wr;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_wr, lo_wr, wr_data,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_wr, lo_wr, wr_data,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Sequential multiply/divide engine with HI/LO registers.
//   clock : rising-edge system clock
//   reset : asynchronous active-low reset, clears all state
//   bus   : muldiv_unit_if.slave (op codes 00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
// Operations run on operand magnitudes for WIDTH iterations (shift-add
// multiply LSB first, restoring divide MSB first), then a FIX cycle applies
// the latched signs and writes HI/LO. Divide by zero skips straight to FIX.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic          clock,
  input logic          reset,
  muldiv_unit_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]      cnt;
  logic               div_q;
  logic               zero_q;
  logic               sign_pq;
  logic               sign_r;
  logic [WIDTH-1:0]   opnd;   // |a| for multiply, |b| (divisor) for divide
  logic [2*WIDTH-1:0] acc;    // product accumulator, or quotient/dividend in the low half
  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;
  logic               dz_q;

  logic               accept;
  logic               is_signed;
  logic               zero_div;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic               last;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_trial;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    accept    = (state == IDLE) && bus.start;
    is_signed = !bus.op[0];
    zero_div  = bus.op[1] && (bus.b == '0);
    abs_a     = (is_signed && bus.a[WIDTH-1]) ? ('0 - bus.a) : bus.a;
    abs_b     = (is_signed && bus.b[WIDTH-1]) ? ('0 - bus.b) : bus.b;
    last      = (cnt == CW'(WIDTH - 1));

    // Multiply step: add the multiplicand into the upper half when the
    // current multiplier bit (acc[0]) is set, then shift the whole thing right.
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);

    // Divide step: shift the next dividend bit into the partial remainder and
    // trial-subtract the divisor; a clear borrow bit means the quotient bit is 1.
    div_trial = {rem, acc[WIDTH-1]} - {2'b00, opnd};
    div_ge    = !div_trial[WIDTH+1];

    prod_fix  = sign_pq ? ('0 - acc) : acc;
    quo_fix   = sign_pq ? ('0 - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    rem_fix   = sign_r  ? ('0 - rem[WIDTH-1:0]) : rem[WIDTH-1:0];
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (bus.start) state_nx = zero_div ? FIX : RUN;
      RUN:  if (last) state_nx = FIX;
      FIX:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      div_q   <= 1'b0;
      zero_q  <= 1'b0;
      sign_pq <= 1'b0;
      sign_r  <= 1'b0;
      opnd    <= '0;
      acc     <= '0;
      rem     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      done_q <= (state == FIX);
      dz_q   <= (state == FIX) && zero_q;
      unique case (state)
        IDLE: begin
          if (bus.hi_wr) hi_q <= bus.wr_data;
          if (bus.lo_wr) lo_q <= bus.wr_data;
          if (accept) begin
            cnt     <= '0;
            div_q   <= bus.op[1];
            zero_q  <= zero_div;
            sign_pq <= is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            sign_r  <= is_signed && bus.a[WIDTH-1];
            opnd    <= bus.op[1] ? abs_b : abs_a;
            acc     <= {{WIDTH{1'b0}}, (bus.op[1] ? abs_a : abs_b)};
            rem     <= '0;
          end
        end
        RUN: begin
          cnt <= cnt + CW'(1);
          if (div_q) begin
            rem <= div_ge ? div_trial[WIDTH:0] : {rem[WIDTH-1:0], acc[WIDTH-1]};
            acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], div_ge};
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
        end
        FIX: begin
          if (!zero_q) begin
            if (div_q) begin
              lo_q <= quo_fix;
              hi_q <= rem_fix;
            end else begin
              {hi_q, lo_q} <= prod_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule
